// File: rtl/rc_tag_scheduler_if.sv
// Request, issue and completion signals of the RC read tag scheduler.
// The scheduler connects through the slave modport.
interface rc_tag_scheduler_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned NUM_TAGS   = 32,
  parameter int unsigned ADDR_WIDTH = 64
);
  localparam int unsigned DEST_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W  = $clog2(NUM_TAGS) + 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*10-1:0]         req_dwlen;

  logic                          rq_valid;
  logic                          rq_ready;
  logic [ADDR_WIDTH-1:0]         rq_addr;
  logic [9:0]                    rq_dwlen;
  logic [7:0]                    rq_tag;

  logic                          cpl_valid;
  logic                          cpl_ready;
  logic                          cpl_sop;
  logic                          cpl_last;
  logic [7:0]                    cpl_tag;
  logic                          cpl_done;
  logic [DEST_W-1:0]             cpl_dest;
  logic                          cpl_err;

  logic [CNT_W-1:0]              tags_free;

  modport master (
    output req_valid, req_addr, req_dwlen, rq_ready,
    output cpl_valid, cpl_ready, cpl_sop, cpl_last, cpl_tag, cpl_done,
    input  req_ready, rq_valid, rq_addr, rq_dwlen, rq_tag, cpl_dest, cpl_err, tags_free
  );

  modport slave (
    input  req_valid, req_addr, req_dwlen, rq_ready,
    input  cpl_valid, cpl_ready, cpl_sop, cpl_last, cpl_tag, cpl_done,
    output req_ready, rq_valid, rq_addr, rq_dwlen, rq_tag, cpl_dest, cpl_err, tags_free
  );
endinterface

// File: rtl/rc_tag_scheduler.sv
// Round-robin read requester arbiter with a tag pool; tags are allocated on issue and
// released when the final completion for the tag arrives.
module rc_tag_scheduler #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned NUM_TAGS   = 32,
  parameter int unsigned ADDR_WIDTH = 64
) (
  input logic               user_clk,
  input logic               user_reset_n,
  rc_tag_scheduler_if.slave bus
);
  localparam int unsigned DEST_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TAG_W  = $clog2(NUM_TAGS);
  localparam int unsigned CNT_W  = TAG_W + 1;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;
  state_e state_q, state_d;

  logic [NUM_TAGS-1:0]   busy_q, busy_d;
  logic [DEST_W-1:0]     owner_q [NUM_TAGS];
  logic [DEST_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      tags_free_q, tags_free_d, busy_cnt;
  logic [ADDR_WIDTH-1:0] rq_addr_q, rq_addr_d;
  logic [9:0]            rq_dwlen_q, rq_dwlen_d;
  logic [7:0]            rq_tag_q, rq_tag_d;
  logic [DEST_W-1:0]     cpl_dest_q, cur_dest;
  logic                  cpl_err_q, cur_err;
  logic [TAG_W-1:0]      cpl_tag_q, cur_tag, sop_tag;

  logic                  found_req, found_tag, grant;
  logic [DEST_W-1:0]     winner, idx;
  logic [TAG_W-1:0]      alloc_tag;
  logic                  cpl_beat, tag_in_range, free_tag;

  // Round-robin search starting at the requester after the last grant.
  always_comb begin
    found_req = 1'b0;
    winner    = '0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = DEST_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!found_req && bus.req_valid[idx]) begin
        found_req = 1'b1;
        winner    = idx;
      end
    end
  end

  always_comb begin
    found_tag = 1'b0;
    alloc_tag = '0;
    for (int unsigned t = 0; t < NUM_TAGS; t++) begin
      if (!found_tag && !busy_q[t]) begin
        found_tag = 1'b1;
        alloc_tag = TAG_W'(t);
      end
    end
  end

  // Reset gates the combinational handshakes so nothing leaks out while held.
  assign grant = user_reset_n && (state_q == StIdle) && found_req && found_tag &&
                 (tags_free_q != '0);

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[winner] = 1'b1;
  end

  assign cpl_beat     = user_reset_n && bus.cpl_valid && bus.cpl_ready;
  assign tag_in_range = 32'(bus.cpl_tag) < NUM_TAGS;
  assign sop_tag      = bus.cpl_tag[TAG_W-1:0];

  // SOP beats resolve owner and error directly; later beats reuse the captured values.
  always_comb begin
    cur_dest = cpl_dest_q;
    cur_err  = cpl_err_q;
    cur_tag  = cpl_tag_q;
    if (cpl_beat && bus.cpl_sop) begin
      cur_dest = tag_in_range ? owner_q[sop_tag] : '0;
      cur_err  = !tag_in_range || !busy_q[sop_tag];
      cur_tag  = sop_tag;
    end
  end

  assign free_tag = cpl_beat && bus.cpl_last && bus.cpl_done && !cur_err;

  always_comb begin
    busy_d = busy_q;
    if (free_tag) busy_d[cur_tag] = 1'b0;
    if (grant) busy_d[alloc_tag] = 1'b1;
    busy_cnt = '0;
    for (int unsigned t = 0; t < NUM_TAGS; t++) begin
      busy_cnt = busy_cnt + CNT_W'(busy_d[t]);
    end
    tags_free_d = CNT_W'(NUM_TAGS) - busy_cnt;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rq_addr_d  = rq_addr_q;
    rq_dwlen_d = rq_dwlen_q;
    rq_tag_d   = rq_tag_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d    = StIssue;
          rr_ptr_d   = (32'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
          rq_addr_d  = bus.req_addr[32'(winner) * ADDR_WIDTH +: ADDR_WIDTH];
          rq_dwlen_d = bus.req_dwlen[32'(winner) * 10 +: 10];
          rq_tag_d   = 8'(alloc_tag);
        end
      end
      StIssue: begin
        if (bus.rq_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q     <= StIdle;
      busy_q      <= '0;
      rr_ptr_q    <= '0;
      tags_free_q <= CNT_W'(NUM_TAGS);
      rq_addr_q   <= '0;
      rq_dwlen_q  <= '0;
      rq_tag_q    <= '0;
      cpl_dest_q  <= '0;
      cpl_err_q   <= 1'b0;
      cpl_tag_q   <= '0;
      for (int unsigned t = 0; t < NUM_TAGS; t++) owner_q[t] <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      rr_ptr_q    <= rr_ptr_d;
      tags_free_q <= tags_free_d;
      rq_addr_q   <= rq_addr_d;
      rq_dwlen_q  <= rq_dwlen_d;
      rq_tag_q    <= rq_tag_d;
      cpl_dest_q  <= cur_dest;
      cpl_err_q   <= cur_err;
      cpl_tag_q   <= cur_tag;
      if (grant) owner_q[alloc_tag] <= winner;
    end
  end

  assign bus.rq_valid  = (state_q == StIssue);
  assign bus.rq_addr   = rq_addr_q;
  assign bus.rq_dwlen  = rq_dwlen_q;
  assign bus.rq_tag    = rq_tag_q;
  assign bus.cpl_dest  = cur_dest;
  assign bus.cpl_err   = cur_err;
  assign bus.tags_free = tags_free_q;
endmodule

// File: tb/tb_rc_tag_scheduler.sv
// Directed bench for rc_tag_scheduler: issued requests are predicted by a small tag/arbiter
// model, queued when stimulus is driven and compared when the DUT issues them.
module tb_rc_tag_scheduler;
  logic user_clk;
  logic user_reset_n;

  rc_tag_scheduler_if #(.NUM_REQ(2), .NUM_TAGS(32), .ADDR_WIDTH(64)) bus ();

  rc_tag_scheduler #(.NUM_REQ(2), .NUM_TAGS(32), .ADDR_WIDTH(64)) dut (
    .user_clk     (user_clk),
    .user_reset_n (user_reset_n),
    .bus          (bus)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [9:0]  dwlen;
    logic [7:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   m_busy [32];
  int   m_owner[32];
  int   m_ptr;
  int   m_free;
  int   seq = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] addr_of(input int r, input int s);
    return (64'(r + 1) << 60) | (64'(s) << 6);
  endfunction

  function automatic logic [9:0] dw_of(input int r, input int s);
    return 10'(s * 2 + r + 1);
  endfunction

  task automatic drive_addrs();
    bus.req_addr  = {addr_of(1, seq), addr_of(0, seq)};
    bus.req_dwlen = {dw_of(1, seq), dw_of(0, seq)};
  endtask

  task automatic model_reset();
    for (int t = 0; t < 32; t++) begin
      m_busy[t]  = 1'b0;
      m_owner[t] = 0;
    end
    m_ptr  = 0;
    m_free = 32;
    exp_q.delete();
  endtask

  // Asserts reset asynchronously mid-cycle, checks held values, releases after a cycle.
  task automatic apply_reset();
    user_reset_n = 1'b0;
    #1;
    check("rst_rq_valid", bus.rq_valid, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_tags_free", bus.tags_free, 32);
    check("rst_rq_tag", bus.rq_tag, 0);
    check("rst_rq_addr", bus.rq_addr, 0);
    check("rst_rq_dwlen", bus.rq_dwlen, 0);
    check("rst_cpl_dest", bus.cpl_dest, 0);
    check("rst_cpl_err", bus.cpl_err, 0);
    @(negedge user_clk);
    check("rst_req_ready_held", bus.req_ready, 0);
    check("rst_rq_valid_held", bus.rq_valid, 0);
    @(posedge user_clk);
    #1 user_reset_n = 1'b1;
    model_reset();
  endtask

  // Precondition: 1ns after a rising edge with the DUT idle and a free tag in the model.
  task automatic issue_req(input logic [1:0] valid, input int stall, input bit complete);
    int   w;
    int   tg;
    int   idx;
    exp_t e;
    exp_t got;
    drive_addrs();
    bus.req_valid = valid;
    w = -1;
    for (int i = 0; i < 2; i++) begin
      idx = (m_ptr + i) % 2;
      if (w < 0 && valid[idx]) w = idx;
    end
    tg = -1;
    for (int t = 0; t < 32; t++) if (tg < 0 && !m_busy[t]) tg = t;
    e.addr  = addr_of(w, seq);
    e.dwlen = dw_of(w, seq);
    e.tag   = 8'(tg);
    exp_q.push_back(e);
    @(negedge user_clk);
    check("grant", bus.req_ready, 64'(1) << w);
    check("free_before_grant", bus.tags_free, 64'(m_free));
    m_busy[tg]  = 1'b1;
    m_owner[tg] = w;
    m_ptr       = (w + 1) % 2;
    m_free--;
    @(posedge user_clk);
    #1;
    seq++;
    drive_addrs();
    bus.rq_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge user_clk);
      check("stall_rq_valid", bus.rq_valid, 1);
      check("stall_req_ready", bus.req_ready, 0);
      check("stall_rq_addr", bus.rq_addr, exp_q[0].addr);
      check("stall_rq_dwlen", bus.rq_dwlen, 64'(exp_q[0].dwlen));
      check("stall_rq_tag", bus.rq_tag, 64'(exp_q[0].tag));
      @(posedge user_clk);
      #1;
    end
    if (!complete) begin
      @(negedge user_clk);
      check("open_rq_valid", bus.rq_valid, 1);
      check("open_rq_tag", bus.rq_tag, 64'(exp_q[0].tag));
      return;
    end
    bus.rq_ready = 1'b1;
    @(negedge user_clk);
    check("rq_valid", bus.rq_valid, 1);
    check("issue_req_ready", bus.req_ready, 0);
    if (exp_q.size() == 0) begin
      check("queue_nonempty", 0, 1);
    end else begin
      got = exp_q.pop_front();
      check("rq_addr", bus.rq_addr, got.addr);
      check("rq_dwlen", bus.rq_dwlen, 64'(got.dwlen));
      check("rq_tag", bus.rq_tag, 64'(got.tag));
    end
    check("free_after_grant", bus.tags_free, 64'(m_free));
    @(posedge user_clk);
    #1;
  endtask

  // Multi-beat TLPs insert a cpl_valid-without-cpl_ready cycle between beats.
  task automatic cpl_tlp(input logic [7:0] tag, input int beats, input logic done);
    logic exp_err;
    int   exp_dest;
    exp_err  = (tag >= 8'd32) ? 1'b1 : !m_busy[tag[4:0]];
    exp_dest = (tag >= 8'd32) ? 0 : m_owner[tag[4:0]];
    for (int k = 0; k < beats; k++) begin
      if (k > 0) begin
        bus.cpl_valid = 1'b1;
        bus.cpl_ready = 1'b0;
        bus.cpl_sop   = 1'b1;
        bus.cpl_last  = 1'b1;
        bus.cpl_done  = 1'b1;
        bus.cpl_tag   = 8'h00;
        @(negedge user_clk);
        check("cpl_err_gap", bus.cpl_err, 64'(exp_err));
        if (!exp_err) check("cpl_dest_gap", bus.cpl_dest, 64'(exp_dest));
        check("cpl_free_gap", bus.tags_free, 64'(m_free));
        @(posedge user_clk);
        #1;
      end
      bus.cpl_valid = 1'b1;
      bus.cpl_ready = 1'b1;
      bus.cpl_sop   = (k == 0);
      bus.cpl_last  = (k == beats - 1);
      bus.cpl_done  = done;
      bus.cpl_tag   = (k == 0) ? tag : 8'hFF;
      @(negedge user_clk);
      check("cpl_err", bus.cpl_err, 64'(exp_err));
      if (!exp_err) check("cpl_dest", bus.cpl_dest, 64'(exp_dest));
      check("cpl_req_ready", bus.req_ready, 0);
      check("cpl_free_during", bus.tags_free, 64'(m_free));
      @(posedge user_clk);
      #1;
    end
    bus.cpl_valid = 1'b0;
    bus.cpl_ready = 1'b0;
    bus.cpl_sop   = 1'b0;
    bus.cpl_last  = 1'b0;
    bus.cpl_done  = 1'b0;
    bus.cpl_tag   = 8'h00;
    if (!exp_err && done) begin
      m_busy[tag[4:0]] = 1'b0;
      m_free++;
    end
  endtask

  task automatic check_free_next(input string name, input int exp);
    @(negedge user_clk);
    check(name, bus.tags_free, 64'(exp));
    @(posedge user_clk);
    #1;
  endtask

  initial begin
    user_reset_n  = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_dwlen = '0;
    bus.rq_ready  = 1'b0;
    bus.cpl_valid = 1'b0;
    bus.cpl_ready = 1'b0;
    bus.cpl_sop   = 1'b0;
    bus.cpl_last  = 1'b0;
    bus.cpl_tag   = 8'h00;
    bus.cpl_done  = 1'b0;
    model_reset();
    #2;
    bus.req_valid = 2'b11;
    apply_reset();

    // Both requesters valid: alternating grants, tags 0..3.
    repeat (4) issue_req(2'b11, 0, 1'b1);
    check("free_after_four", bus.tags_free, 28);

    // Issue held off for five cycles.
    issue_req(2'b11, 5, 1'b1);

    // Only requester 1 valid: pointer must skip requester 0.
    issue_req(2'b10, 0, 1'b1);
    issue_req(2'b10, 0, 1'b1);
    bus.req_valid = 2'b00;

    // Three-beat completion for tag 1 (owner requester 1).
    cpl_tlp(8'd1, 3, 1'b1);
    check_free_next("free_after_tag1", m_free);

    // Out-of-range tag, tag no longer busy, then a partial completion.
    cpl_tlp(8'd40, 2, 1'b1);
    cpl_tlp(8'd1, 1, 1'b1);
    cpl_tlp(8'd2, 1, 1'b0);
    check_free_next("free_after_errors", 26);

    // Exhaust the pool, then verify grants stop.
    while (m_free > 0) issue_req(2'b11, 0, 1'b1);
    bus.req_valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge user_clk);
      check("full_req_ready", bus.req_ready, 0);
      check("full_rq_valid", bus.rq_valid, 0);
      check("full_tags_free", bus.tags_free, 0);
      @(posedge user_clk);
      #1;
    end

    // Freeing tag 7 makes it the next allocated tag.
    cpl_tlp(8'd7, 1, 1'b1);
    issue_req(2'b11, 0, 1'b1);
    check("refill_tags_free", bus.tags_free, 0);

    // Reset with ten tags outstanding, one of them mid-issue.
    bus.req_valid = 2'b00;
    apply_reset();
    repeat (9) issue_req(2'b11, 0, 1'b1);
    issue_req(2'b11, 0, 1'b0);
    check("outstanding_ten", bus.tags_free, 22);
    apply_reset();
    issue_req(2'b11, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rc_tag_scheduler.md
RC_TAG_SCHEDULER -- requirements
Module: rc_tag_scheduler

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter NUM_REQ, default 2, SHALL set the number of read requesters (range 2..8).
REQ-003 Parameter NUM_TAGS, default 32, SHALL set the size of the tag pool (power of 2, max 256).
REQ-004 Parameter ADDR_WIDTH, default 64, SHALL set the read address width.
REQ-005 user_clk  in  1  SHALL be the sole clock.
REQ-006 user_reset_n  in  1  SHALL be the asynchronous active-low reset.
REQ-007 req_valid  in  NUM_REQ  SHALL flag a pending read request per requester.
REQ-008 req_ready  out  NUM_REQ  SHALL acknowledge acceptance, at most one bit high per cycle.
REQ-009 req_addr  in  NUM_REQ*ADDR_WIDTH  SHALL carry the read addresses, requester i in slice i.
REQ-010 req_dwlen  in  NUM_REQ*10  SHALL carry the read lengths in DW, requester i in slice i.
REQ-011 rq_valid / rq_ready  out / in  1 / 1  SHALL form the issued-request handshake.
REQ-012 rq_addr, rq_dwlen, rq_tag  out  ADDR_WIDTH, 10, 8  SHALL carry the issued request fields.
REQ-013 cpl_valid, cpl_ready, cpl_sop, cpl_last  in  1 each  SHALL describe the RC completion beat and its position.
REQ-014 cpl_tag  in  8  SHALL carry the completion tag, sampled on SOP beats only.
REQ-015 cpl_done  in  1  SHALL flag that a completion is the final one for its request, sampled on the last beat.
REQ-016 cpl_dest  out  max(1,clog2(NUM_REQ))  SHALL give the owning requester of the current completion.
REQ-017 cpl_err  out  1  SHALL flag a completion whose tag is not outstanding.
REQ-018 tags_free  out  clog2(NUM_TAGS)+1  SHALL give the count of unallocated tags.

Function
REQ-019 The block SHALL keep a busy bit and an owner index per tag.
REQ-020 Request sequencing SHALL use a two-state FSM, IDLE and ISSUE.
REQ-021 In IDLE with any req_valid high and tags_free>0, the block SHALL pick a winner round-robin, starting from the index after the last grant.
REQ-022 In that same cycle, it SHALL assert req_ready[winner] combinationally and latch the winner's addr and dwlen.
REQ-023 It SHALL also allocate the lowest-numbered free tag, set its busy bit, record the owner, and go to ISSUE.
REQ-024 In IDLE with tags_free==0, req_ready SHALL stay 0 and the state SHALL remain IDLE.
REQ-025 In ISSUE, rq_valid SHALL be 1 with all rq_* fields stable until rq_ready; on rq_valid&&rq_ready the FSM SHALL return to IDLE.
REQ-026 Peak issue rate SHALL be one request per 2 cycles.
REQ-027 A completion beat SHALL be defined as cpl_valid&&cpl_ready; inputs SHALL be ignored otherwise.
REQ-028 On an SOP beat, cpl_dest SHALL equal owner[cpl_tag] combinationally, and the block SHALL register it for the following non-SOP beats.
REQ-029 On an SOP beat, cpl_err SHALL be 1 when cpl_tag>=NUM_TAGS or the tag is not busy; the value SHALL be held through the last beat.
REQ-030 On a beat with cpl_last&&cpl_done and no error, the busy bit of the SOP tag SHALL clear on the next edge.
REQ-031 On a beat with cpl_done=0, the tag SHALL stay busy (partial completions).
REQ-032 Erroneous completions SHALL never modify the tag state.
REQ-033 A single-beat TLP (cpl_sop&&cpl_last) SHALL use cpl_tag from that same beat.
REQ-034 Allocation SHALL use the registered busy vector, so a tag freed in cycle N is allocatable from cycle N+1.
REQ-035 A simultaneous allocate and free SHALL both take effect, leaving tags_free unchanged.
REQ-036 tags_free SHALL be registered and track NUM_TAGS minus the popcount of busy, with no wrap below 0 or above NUM_TAGS.

Reset
REQ-037 While user_reset_n=0, the block SHALL hold:
- state=IDLE, rq_valid=0, req_ready=0
- all busy bits 0, tags_free=NUM_TAGS
- round-robin pointer=0, cpl_dest=0, cpl_err=0
- rq_addr, rq_dwlen and rq_tag = 0
REQ-038 Reset asserted mid-issue or mid-completion SHALL abandon all outstanding tags with no further req_ready or rq_valid activity.

Verification
REQ-039 Both requesters valid from reset, rq_ready=1 -> grants alternate 0,1,0,1 with rq_tag 0,1,2,3, and tags_free falls 32->28.
REQ-040 rq_ready=0 for 5 cycles in ISSUE -> rq_valid and all fields stay stable, and no req_ready pulses.
REQ-041 Pool exhausted (32 issued) -> req_ready stays 0; a completion with tag 7, cpl_last=1, cpl_done=1 frees tag 7, and the next grant carries rq_tag=7 one cycle later.
REQ-042 3-beat completion for tag 1 (owned by requester 1), cpl_done=1 -> cpl_dest=1 on all beats, and tag 1 is freed after the last beat only.
REQ-043 Completion with tag 40 -> cpl_err=1 for the whole TLP and tags_free is unchanged; partial completion (cpl_done=0) -> tag stays busy.
REQ-044 Reset pulsed with 10 tags outstanding -> tags_free=32 and rq_valid=0 immediately.
